hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core; it consumes the D-stage Tuse/Tnew/destination information and drives the D_E register's `clr`, the F/D freeze, and all forwarding mux selects. It keeps its own shadow pipeline of in-flight writers (E, M, W slots) that advances in lockstep with the datapath registers. Tnew in each slot decrements with saturation at 0, exactly as the D→E register does. Stall, bubble and forward decisions are combinational from shadow state plus current D-stage inputs.

---
 rtl/hazard_pkg.sv | 44 ++++
 rtl/hazard_slot.sv | 36 +++
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, select encodings and helpers for the pipeline
// hazard controller (shadow slot layout, Tnew/Tuse widths, forward selects).
package hazard_pkg;

  typedef logic [1:0] tnew_t;
  typedef logic [1:0] tuse_t;
  typedef logic [4:0] regaddr_t;
  typedef logic [1:0] fwd_t;

  // Forward mux select encodings shared by D-, E- and M-stage selects
  localparam fwd_t FWD_GRF = 2'd0;
  localparam fwd_t FWD_W   = 2'd1;
  localparam fwd_t FWD_M   = 2'd2;
  localparam fwd_t FWD_E   = 2'd3;

  // A Tuse of 3 marks an operand the instruction never reads
  localparam tuse_t TUSE_NONE = 2'd3;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic     valid;
    logic     regWrite;
    regaddr_t A_rs;
    regaddr_t A_rt;
    regaddr_t Awrite;
    tnew_t    Tnew;
  } slot_t;

  // Tnew countdown that sticks at zero, matching the D->E register
  function automatic tnew_t sat_dec(input tnew_t t);
    return (t == 2'd0) ? 2'd0 : tnew_t'(t - 2'd1);
  endfunction

  // A slot only produces a result when it is live, writes, and not to $0
  function automatic logic isWriter(input slot_t s);
    return s.valid && s.regWrite && (s.Awrite != 5'd0);
  endfunction

  // True when slot s will write register a (a must be non-zero)
  function automatic logic opMatch(input slot_t s, input regaddr_t a);
    return (a != 5'd0) && isWriter(s) && (s.Awrite == a);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// hazard_slot: one shadow pipeline slot. Loads the upstream slot each clock,
// decrementing Tnew with saturation, or loads a bubble when told to.
module hazard_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_bubble,
  input  slot_t i_slot,
  output slot_t o_slot
);

  slot_t r_slot;
  slot_t w_next;

  // Next slot contents: bubble clears everything, otherwise age the upstream entry
  always_comb begin
    w_next = '0;
    if (!i_bubble) begin
      w_next      = i_slot;
      w_next.Tnew = sat_dec(i_slot.Tnew);
    end
  end

  // Slot register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_next;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall / bubble / forward controller for the five-stage MIPS core.
// Tracks in-flight writers in a shadow E/M/W pipeline and decides combinationally
// from that state plus the D-stage Tuse/Tnew information.
// Build option: define HAZARD_FORWARD_EN for full forwarding with Tnew/Tuse stalls;
// without it every Fwd select is 0 and any E/M writer hit on a used source stalls.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int NSLOT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A_rsD,
  input  logic [4:0] A_rtD,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] AwriteD,
  input  logic       RegWriteD,
  input  logic [1:0] TnewD,
  output logic       stall,
  output logic       clrE,
  output logic [1:0] FwdRsD,
  output logic [1:0] FwdRtD,
  output logic [1:0] FwdRsE,
  output logic [1:0] FwdRtE,
  output logic       FwdRtM
);

  localparam int SLOT_E = 0;
  localparam int SLOT_M = 1;
  localparam int SLOT_W = 2;

  slot_t w_dSlot;
  slot_t w_slotIn [NSLOT];
  slot_t w_slot   [NSLOT];
  logic  w_bubble [NSLOT];
  slot_t w_e;
  slot_t w_m;
  slot_t w_w;
  logic  w_stall;
  logic  w_stallRs;
  logic  w_stallRt;

  assign w_dSlot = '{valid:    1'b1,
                     regWrite: RegWriteD,
                     A_rs:     A_rsD,
                     A_rt:     A_rtD,
                     Awrite:   AwriteD,
                     Tnew:     TnewD};

  // Shadow pipeline: slot 0 (E) takes the D instruction or a bubble on stall,
  // each later slot takes its predecessor every clock.
  genvar g;
  generate
    for (g = 0; g < NSLOT; g = g + 1) begin : gSlot
      if (g == 0) begin : gHead
        assign w_slotIn[g] = w_dSlot;
        assign w_bubble[g] = w_stall;
      end else begin : gBody
        assign w_slotIn[g] = w_slot[g-1];
        assign w_bubble[g] = 1'b0;
      end
      hazard_slot u_slot (
        .clk      (clk),
        .reset    (reset),
        .i_bubble (w_bubble[g]),
        .i_slot   (w_slotIn[g]),
        .o_slot   (w_slot[g])
      );
    end
  endgenerate

  assign w_e = w_slot[SLOT_E];
  assign w_m = w_slot[SLOT_M];
  assign w_w = w_slot[SLOT_W];

`ifdef HAZARD_FORWARD_EN
  // Stall when an E or M writer of the operand will not have its result in time
  function automatic logic opStall(input regaddr_t a, input tuse_t tuse,
                                   input slot_t e, input slot_t m);
    return (opMatch(e, a) && (e.Tnew > tuse)) ||
           (opMatch(m, a) && (m.Tnew > tuse));
  endfunction

  // D-stage source: youngest matching slot decides; a not-ready match means GRF
  // and lets the stall logic hold the instruction instead.
  function automatic fwd_t dFwd(input regaddr_t a, input slot_t e,
                                input slot_t m, input slot_t w);
    fwd_t sel;
    sel = FWD_GRF;
    if (opMatch(e, a)) begin
      sel = (e.Tnew == 2'd0) ? FWD_E : FWD_GRF;
    end else if (opMatch(m, a)) begin
      sel = (m.Tnew == 2'd0) ? FWD_M : FWD_GRF;
    end else if (opMatch(w, a)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // E-stage source: a ready M result beats the W result
  function automatic fwd_t eFwd(input regaddr_t a, input slot_t m, input slot_t w);
    fwd_t sel;
    sel = FWD_GRF;
    if (opMatch(m, a) && (m.Tnew == 2'd0)) begin
      sel = FWD_M;
    end else if (opMatch(w, a)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction
`else
  // Without forwarding any pending E/M write to a used source must drain first
  function automatic logic opStall(input regaddr_t a, input tuse_t tuse,
                                   input slot_t e, input slot_t m);
    return (tuse != TUSE_NONE) && (opMatch(e, a) || opMatch(m, a));
  endfunction
`endif

  // Per-operand stall requests combined into the freeze / D_E clear
  always_comb begin
    w_stallRs = opStall(A_rsD, TuseRsD, w_e, w_m);
    w_stallRt = opStall(A_rtD, TuseRtD, w_e, w_m);
    w_stall   = w_stallRs || w_stallRt;
  end

  assign stall = w_stall;
  assign clrE  = w_stall;

  // Forward mux selects for the D, E and M stage operands
  always_comb begin
    FwdRsD = FWD_GRF;
    FwdRtD = FWD_GRF;
    FwdRsE = FWD_GRF;
    FwdRtE = FWD_GRF;
    FwdRtM = 1'b0;
`ifdef HAZARD_FORWARD_EN
    FwdRsD = dFwd(A_rsD, w_e, w_m, w_w);
    FwdRtD = dFwd(A_rtD, w_e, w_m, w_w);
    FwdRsE = eFwd(w_e.A_rs, w_m, w_w);
    FwdRtE = eFwd(w_e.A_rt, w_m, w_w);
    FwdRtM = opMatch(w_w, w_m.A_rt) && w_m.valid;
`endif
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of the hazard controller for the build in use
// (expectations switch on HAZARD_FORWARD_EN).
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [4:0] A_rsD;
  logic [4:0] A_rtD;
  logic [1:0] TuseRsD;
  logic [1:0] TuseRtD;
  logic [4:0] AwriteD;
  logic       RegWriteD;
  logic [1:0] TnewD;
  logic       stall;
  logic       clrE;
  logic [1:0] FwdRsD;
  logic [1:0] FwdRtD;
  logic [1:0] FwdRsE;
  logic [1:0] FwdRtE;
  logic       FwdRtM;

  int vectors;
  int miscompares;

  hazard_unit #(.NSLOT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .A_rsD     (A_rsD),
    .A_rtD     (A_rtD),
    .TuseRsD   (TuseRsD),
    .TuseRtD   (TuseRtD),
    .AwriteD   (AwriteD),
    .RegWriteD (RegWriteD),
    .TnewD     (TnewD),
    .stall     (stall),
    .clrE      (clrE),
    .FwdRsD    (FwdRsD),
    .FwdRtD    (FwdRtD),
    .FwdRsE    (FwdRsE),
    .FwdRtE    (FwdRtE),
    .FwdRtM    (FwdRtM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one D-stage instruction and let the combinational outputs settle
  task automatic applyStimulus(input logic [4:0] rs, input logic [1:0] tuseRs,
                               input logic [4:0] rt, input logic [1:0] tuseRt,
                               input logic [4:0] aw, input logic rw,
                               input logic [1:0] tnew);
    A_rsD = rs; TuseRsD = tuseRs; A_rtD = rt; TuseRtD = tuseRt;
    AwriteD = aw; RegWriteD = rw; TnewD = tnew;
    #1;
  endtask

  task automatic nop;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic flush;
    nop();
    repeat (3) tick();
  endtask

  // Hold the current D instruction until stall drops; returns stall cycles seen
  task automatic waitStall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 8) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    nop();
    tick(); tick();
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
    vectors++;
    if (clrE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clrE: got %0b expected 0", clrE); end
    vectors++;
    if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin
      miscompares++; $display("[TB] FAIL reset_fwd: got %b expected 000000000", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM});
    end
    reset = 1'b0;
    applyStimulus(5'd5, 2'd0, 5'd6, 2'd0, 5'd0, 1'b0, 2'd0);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_stall: got %0b expected 0", stall); end
    flush();
  endtask

  task automatic test_alu_forward;
    int n;
    applyStimulus(5'd4, 2'd1, 5'd5, 2'd1, 5'd1, 1'b1, 2'd2);
    tick();
    applyStimulus(5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 1'b1, 2'd2);
    vectors++;
    if (FwdRsD !== 2'd0) begin miscompares++; $display("[TB] FAIL alu_rsD_notready: got %0d expected 0", FwdRsD); end
    waitStall(n);
    vectors++;
    if (n != (FWD_ON ? 0 : 2)) begin miscompares++; $display("[TB] FAIL alu_stall_cycles: got %0d expected %0d", n, FWD_ON ? 0 : 2); end
    tick();
    nop();
    vectors++;
    if (FwdRsE !== (FWD_ON ? 2'd2 : 2'd0)) begin miscompares++; $display("[TB] FAIL alu_rsE: got %0d expected %0d", FwdRsE, FWD_ON ? 2 : 0); end
    vectors++;
    if (FwdRtE !== 2'd0) begin miscompares++; $display("[TB] FAIL alu_rtE: got %0d expected 0", FwdRtE); end
    flush();
  endtask

  task automatic test_lw_use;
    int n;
    applyStimulus(5'd29, 2'd1, 5'd5, 2'd3, 5'd5, 1'b1, 2'd3);
    tick();
    applyStimulus(5'd5, 2'd1, 5'd7, 2'd1, 5'd6, 1'b1, 2'd2);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL lwuse_stall: got %0b expected 1", stall); end
    vectors++;
    if (clrE !== 1'b1) begin miscompares++; $display("[TB] FAIL lwuse_clrE: got %0b expected 1", clrE); end
    waitStall(n);
    vectors++;
    if (n != (FWD_ON ? 1 : 2)) begin miscompares++; $display("[TB] FAIL lwuse_stall_cycles: got %0d expected %0d", n, FWD_ON ? 1 : 2); end
    vectors++;
    if (FwdRsD !== 2'd0) begin miscompares++; $display("[TB] FAIL lwuse_rsD_blocked: got %0d expected 0", FwdRsD); end
    tick();
    nop();
    vectors++;
    if (FwdRsE !== (FWD_ON ? 2'd1 : 2'd0)) begin miscompares++; $display("[TB] FAIL lwuse_rsE: got %0d expected %0d", FwdRsE, FWD_ON ? 1 : 0); end
    flush();
  endtask

  task automatic test_store_data;
    int n;
    applyStimulus(5'd29, 2'd1, 5'd5, 2'd3, 5'd5, 1'b1, 2'd3);
    tick();
    applyStimulus(5'd8, 2'd1, 5'd5, 2'd2, 5'd0, 1'b0, 2'd0);
    waitStall(n);
    vectors++;
    if (n != (FWD_ON ? 0 : 2)) begin miscompares++; $display("[TB] FAIL store_stall_cycles: got %0d expected %0d", n, FWD_ON ? 0 : 2); end
    tick();
    nop();
    tick();
    vectors++;
    if (FwdRtM !== FWD_ON) begin miscompares++; $display("[TB] FAIL store_rtM: got %0b expected %0b", FwdRtM, FWD_ON); end
    flush();
  endtask

  task automatic test_lw_beq;
    int n;
    applyStimulus(5'd29, 2'd1, 5'd5, 2'd3, 5'd5, 1'b1, 2'd3);
    tick();
    applyStimulus(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    waitStall(n);
    vectors++;
    if (n != 2) begin miscompares++; $display("[TB] FAIL beq_stall_cycles: got %0d expected 2", n); end
    vectors++;
    if (FwdRsD !== (FWD_ON ? 2'd1 : 2'd0)) begin miscompares++; $display("[TB] FAIL beq_rsD: got %0d expected %0d", FwdRsD, FWD_ON ? 1 : 0); end
    vectors++;
    if (FwdRtD !== 2'd0) begin miscompares++; $display("[TB] FAIL beq_rtD_zero: got %0d expected 0", FwdRtD); end
    flush();
  endtask

  task automatic test_jal_jr;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 1'b1, 2'd1);
    tick();
    applyStimulus(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    vectors++;
    if (stall !== !FWD_ON) begin miscompares++; $display("[TB] FAIL jr_stall: got %0b expected %0b", stall, !FWD_ON); end
    vectors++;
    if (FwdRsD !== (FWD_ON ? 2'd3 : 2'd0)) begin miscompares++; $display("[TB] FAIL jr_rsD: got %0d expected %0d", FwdRsD, FWD_ON ? 3 : 0); end
    flush();
  endtask

  task automatic test_priority;
    int n;
    // Two ready writers of $9 in E and M: the younger one in E must win
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1);
    tick();
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1);
    tick();
    applyStimulus(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    vectors++;
    if (FwdRsD !== (FWD_ON ? 2'd3 : 2'd0)) begin miscompares++; $display("[TB] FAIL prio_rsD: got %0d expected %0d", FwdRsD, FWD_ON ? 3 : 0); end
    vectors++;
    if (stall !== !FWD_ON) begin miscompares++; $display("[TB] FAIL prio_stall: got %0b expected %0b", stall, !FWD_ON); end
    flush();
    // ALU writers of $10 in M and W when the reader reaches E: M must win
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 1'b1, 2'd2);
    tick();
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 1'b1, 2'd2);
    tick();
    applyStimulus(5'd11, 2'd1, 5'd10, 2'd1, 5'd12, 1'b1, 2'd2);
    waitStall(n);
    vectors++;
    if (n != (FWD_ON ? 0 : 2)) begin miscompares++; $display("[TB] FAIL prio_stall_cycles: got %0d expected %0d", n, FWD_ON ? 0 : 2); end
    tick();
    nop();
    vectors++;
    if (FwdRtE !== (FWD_ON ? 2'd2 : 2'd0)) begin miscompares++; $display("[TB] FAIL prio_rtE: got %0d expected %0d", FwdRtE, FWD_ON ? 2 : 0); end
    vectors++;
    if (FwdRsE !== 2'd0) begin miscompares++; $display("[TB] FAIL prio_rsE: got %0d expected 0", FwdRsE); end
    flush();
  endtask

  task automatic test_zero_reg;
    applyStimulus(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd3);
    tick();
    applyStimulus(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_stall: got %0b expected 0", stall); end
    vectors++;
    if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin
      miscompares++; $display("[TB] FAIL zero_fwd_d: got %b expected 000000000", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM});
    end
    tick();
    nop();
    vectors++;
    if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin
      miscompares++; $display("[TB] FAIL zero_fwd_e: got %b expected 000000000", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM});
    end
    flush();
  endtask

  task automatic test_reset_mid_stall;
    applyStimulus(5'd29, 2'd1, 5'd5, 2'd3, 5'd5, 1'b1, 2'd3);
    tick();
    applyStimulus(5'd5, 2'd1, 5'd7, 2'd1, 5'd6, 1'b1, 2'd2);
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pre_stall: got %0b expected 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_stall: got %0b expected 0", stall); end
    vectors++;
    if (clrE !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_clrE: got %0b expected 0", clrE); end
    vectors++;
    if ({FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM} !== 9'd0) begin
      miscompares++; $display("[TB] FAIL rstmid_fwd: got %b expected 000000000", {FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM});
    end
    flush();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    nop();
    $display("[TB] hazard_unit bench, forwarding build = %0b", FWD_ON);
    test_reset();
    test_alu_forward();
    test_lw_use();
    test_store_data();
    test_lw_beq();
    test_jal_jr();
    test_priority();
    test_zero_reg();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
